mem_req_ctrl: RTL

Processor-side initiator for the fixed-latency instruction/data memory.
- Accepts requests from two clients: the instruction-fetch unit (IF) and the load/store unit (D).
- Arbitrates between them and drives the memory request interface with registered signals.
- Tracks one outstanding read per client and routes in-order memory responses back by the is_instr tag.
- Detects protocol errors: timeout, unexpected response, illegal request.

---
 rtl/params_pkg.sv | 15 +
 rtl/mem_req_ctrl_if.sv | 31 +++
 rtl/mem_req_ctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/params_pkg.sv
// Shared processor-wide parameters and types.
//   ADDR_WIDTH    : memory address width
//   DATA_WIDTH    : memory data width
//   access_size_t : BYTE or WORD memory access
package params_pkg;

    parameter int ADDR_WIDTH = 32;
    parameter int DATA_WIDTH = 32;

    typedef enum logic {
        BYTE = 1'b0,
        WORD = 1'b1
    } access_size_t;

endpackage

// File: rtl/mem_req_ctrl_if.sv
// Request/response bus between the processor-side initiator and the
// fixed-latency instruction/data memory.
//   master : request side (drives rd/wr request, tag, address, data, size;
//            receives data_valid, data_is_instr, data)
//   slave  : memory side (mirror of master)
interface mem_req_ctrl_if #(
    parameter int ADDR_WIDTH = params_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = params_pkg::DATA_WIDTH
);

    logic                      rd_req_valid;
    logic                      wr_req_valid;
    logic                      req_is_instr;
    logic [ADDR_WIDTH-1:0]     address;
    logic [DATA_WIDTH-1:0]     wr_data;
    params_pkg::access_size_t  access_size;
    logic                      data_valid;
    logic                      data_is_instr;
    logic [DATA_WIDTH-1:0]     data;

    modport master (
        output rd_req_valid, wr_req_valid, req_is_instr, address, wr_data, access_size,
        input  data_valid, data_is_instr, data
    );

    modport slave (
        input  rd_req_valid, wr_req_valid, req_is_instr, address, wr_data, access_size,
        output data_valid, data_is_instr, data
    );

endinterface

// File: rtl/mem_req_ctrl.sv
// Processor-side initiator for the fixed-latency instruction/data memory.
// Arbitrates between instruction fetch (IF) and load/store (D) clients,
// issues one registered memory request per cycle, routes in-order responses
// back by their is_instr tag and flags protocol errors.
//   clk_i, rst_i        : clock, asynchronous active-low reset
//   if_*                : fetch request (WORD read) / response
//   d_*                 : load/store request / load response / store done
//   err_o               : sticky [0] timeout, [1] unexpected response,
//                         [2] load and store requested together
//   mem                 : memory bus (master side)
module mem_req_ctrl #(
    parameter int ADDR_WIDTH = params_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = params_pkg::DATA_WIDTH,
    parameter int TIMEOUT    = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,

    input  logic                     if_req_valid_i,
    input  logic [ADDR_WIDTH-1:0]    if_addr_i,
    output logic                     if_req_ready_o,
    output logic                     if_resp_valid_o,
    output logic [DATA_WIDTH-1:0]    if_resp_data_o,

    input  logic                     d_rd_req_i,
    input  logic                     d_wr_req_i,
    input  logic [ADDR_WIDTH-1:0]    d_addr_i,
    input  logic [DATA_WIDTH-1:0]    d_wr_data_i,
    input  params_pkg::access_size_t d_access_size_i,
    output logic                     d_req_ready_o,
    output logic                     d_resp_valid_o,
    output logic [DATA_WIDTH-1:0]    d_resp_data_o,
    output logic                     d_wr_done_o,

    output logic [2:0]               err_o,

    mem_req_ctrl_if.master           mem
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } client_state_t;

    client_state_t            if_state;
    client_state_t            d_state;
    logic [CW-1:0]            if_cnt;
    logic [CW-1:0]            d_cnt;
    logic                     rr_d;      // 1: D wins the next contended cycle
    params_pkg::access_size_t d_size_q;  // size of the outstanding load

    logic if_elig;
    logic d_elig;
    logic grant_if;
    logic grant_d;
    logic rsp_if;
    logic rsp_d;

    always_comb begin
        if_elig  = if_req_valid_i & (if_state == IDLE);
        d_elig   = (d_rd_req_i | d_wr_req_i) & (d_state == IDLE);
        grant_if = if_elig & (~d_elig | ~rr_d);
        grant_d  = d_elig & (~if_elig | rr_d);
        rsp_if   = mem.data_valid & mem.data_is_instr;
        rsp_d    = mem.data_valid & ~mem.data_is_instr;
    end

    // Eligibility already requires IDLE, so the grant is the ready.
    assign if_req_ready_o = grant_if;
    assign d_req_ready_o  = grant_d;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            if_state         <= IDLE;
            d_state          <= IDLE;
            if_cnt           <= '0;
            d_cnt            <= '0;
            rr_d             <= 1'b0;
            d_size_q         <= params_pkg::BYTE;
            mem.rd_req_valid <= 1'b0;
            mem.wr_req_valid <= 1'b0;
            mem.req_is_instr <= 1'b0;
            mem.address      <= '0;
            mem.wr_data      <= '0;
            mem.access_size  <= params_pkg::BYTE;
            if_resp_valid_o  <= 1'b0;
            if_resp_data_o   <= '0;
            d_resp_valid_o   <= 1'b0;
            d_resp_data_o    <= '0;
            d_wr_done_o      <= 1'b0;
            err_o            <= '0;
        end else begin
            // Single-cycle pulses default low every cycle.
            mem.rd_req_valid <= 1'b0;
            mem.wr_req_valid <= 1'b0;
            mem.req_is_instr <= 1'b0;
            mem.address      <= '0;
            mem.wr_data      <= '0;
            mem.access_size  <= params_pkg::BYTE;
            if_resp_valid_o  <= 1'b0;
            if_resp_data_o   <= '0;
            d_resp_valid_o   <= 1'b0;
            d_resp_data_o    <= '0;
            d_wr_done_o      <= 1'b0;

            // Issue
            if (grant_if) begin
                mem.rd_req_valid <= 1'b1;
                mem.req_is_instr <= 1'b1;
                mem.address      <= if_addr_i;
                mem.access_size  <= params_pkg::WORD;
            end else if (grant_d) begin
                // A simultaneous load+store request is issued as the store.
                mem.rd_req_valid <= ~d_wr_req_i;
                mem.wr_req_valid <= d_wr_req_i;
                mem.address      <= d_addr_i;
                mem.wr_data      <= d_wr_req_i ? d_wr_data_i : '0;
                mem.access_size  <= d_access_size_i;
                d_wr_done_o      <= d_wr_req_i;
                if (d_rd_req_i && d_wr_req_i) begin
                    err_o[2] <= 1'b1;
                end
            end

            if (if_elig && d_elig) begin
                rr_d <= ~rr_d;
            end

            // IF client
            case (if_state)
                IDLE: begin
                    if (rsp_if) begin
                        err_o[1] <= 1'b1;
                    end
                    if (grant_if) begin
                        if_state <= WAIT;
                        if_cnt   <= '0;
                    end
                end
                WAIT: begin
                    if (rsp_if) begin
                        if_resp_valid_o <= 1'b1;
                        if_resp_data_o  <= mem.data;
                        if_state        <= IDLE;
                    end else if (if_cnt == CW'(TIMEOUT - 1)) begin
                        err_o[0] <= 1'b1;
                        if_state <= IDLE;
                    end else begin
                        if_cnt <= if_cnt + 1'b1;
                    end
                end
                default: if_state <= IDLE;
            endcase

            // D client: stores are posted and never enter WAIT.
            case (d_state)
                IDLE: begin
                    if (rsp_d) begin
                        err_o[1] <= 1'b1;
                    end
                    if (grant_d && !d_wr_req_i) begin
                        d_state  <= WAIT;
                        d_cnt    <= '0;
                        d_size_q <= d_access_size_i;
                    end
                end
                WAIT: begin
                    if (rsp_d) begin
                        d_resp_valid_o <= 1'b1;
                        d_resp_data_o  <= (d_size_q == params_pkg::BYTE)
                                        ? DATA_WIDTH'(mem.data[7:0]) : mem.data;
                        d_state        <= IDLE;
                    end else if (d_cnt == CW'(TIMEOUT - 1)) begin
                        err_o[0] <= 1'b1;
                        d_state  <= IDLE;
                    end else begin
                        d_cnt <= d_cnt + 1'b1;
                    end
                end
                default: d_state <= IDLE;
            endcase
        end
    end

endmodule
